updown_counter_lim: RTL and testbench

UPDOWN_COUNTER_LIM -- requirements
Module: updown_counter_lim

---
 rtl/updown_counter_lim.sv | 133 +++++++++++++
 tb/tb_updown_counter_lim.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/updown_counter_lim.sv
// Up/down counter bounded to [MIN_VAL, MAX_VAL] with wrap or saturate behaviour.
// Overflow, underflow and error are reported as one-cycle pulses.
module updown_counter_lim #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MIN_VAL = '0,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter bit               SAT     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   MIN_EXT   = {1'b0, MIN_VAL};
    localparam logic [WIDTH:0]   MAX_EXT   = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0]   RANGE_EXT = MAX_EXT - MIN_EXT;
    // Wrapped results are always in range, so they can be formed modulo 2**WIDTH.
    localparam logic [WIDTH-1:0] UP_ADJ    = MIN_VAL - MAX_VAL - ONE;
    localparam logic [WIDTH-1:0] DN_ADJ    = MAX_VAL + ONE - MIN_VAL;

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             err_reg, err_next;

    logic             below_min;
    logic             above_max;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   floor_ext;
    logic [WIDTH-1:0] wrap_up;
    logic [WIDTH-1:0] wrap_dn;

    // Limit comparisons are dropped when a limit sits at the edge of the value range.
    generate
        if (MIN_VAL == '0) begin : g_no_min_chk
            assign below_min = 1'b0;
        end else begin : g_min_chk
            assign below_min = (load_val < MIN_VAL);
        end
        if (MAX_VAL == {WIDTH{1'b1}}) begin : g_no_max_chk
            assign above_max = 1'b0;
        end else begin : g_max_chk
            assign above_max = (load_val > MAX_VAL);
        end
    endgenerate

    assign cnt_ext   = {1'b0, cnt_reg};
    assign step_ext  = {1'b0, step};
    assign sum_ext   = cnt_ext + step_ext;
    assign floor_ext = MIN_EXT + step_ext;
    assign wrap_up   = cnt_reg + step + UP_ADJ;
    assign wrap_dn   = cnt_reg - step + DN_ADJ;

    always_comb begin
        cnt_next = cnt_reg;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        err_next = 1'b0;
        if (clr) begin
            cnt_next = MIN_VAL;
        end else if (load) begin
            if (below_min) begin
                cnt_next = MIN_VAL;
                err_next = 1'b1;
            end else if (above_max) begin
                cnt_next = MAX_VAL;
                err_next = 1'b1;
            end else begin
                cnt_next = load_val;
            end
        end else if ((inc ^ dec) && (step != '0)) begin
            if (!SAT && (step_ext > RANGE_EXT)) begin
                // A step wider than the whole range has no meaningful wrap result.
                err_next = 1'b1;
            end else if (inc) begin
                if (sum_ext > MAX_EXT) begin
                    ovf_next = 1'b1;
                    cnt_next = SAT ? MAX_VAL : wrap_up;
                end else begin
                    cnt_next = cnt_reg + step;
                end
            end else begin
                if (cnt_ext < floor_ext) begin
                    unf_next = 1'b1;
                    cnt_next = SAT ? MIN_VAL : wrap_dn;
                end else begin
                    cnt_next = cnt_reg - step;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= MIN_VAL;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
            err_reg <= err_next;
        end
    end

    assign cnt    = cnt_reg;
    assign ovf    = ovf_reg;
    assign unf    = unf_reg;
    assign err    = err_reg;
    assign at_max = (cnt_reg == MAX_VAL);
    assign at_min = (cnt_reg == MIN_VAL);

    a_no_x : assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({cnt_reg, ovf_reg, unf_reg, err_reg}));
    a_flags_excl : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({ovf_reg, unf_reg, err_reg}));

endmodule

// File: tb/tb_updown_counter_lim.sv
// Directed test of updown_counter_lim across four parameter sets sharing one stimulus stream.
module tb_updown_counter_lim;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0, load = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [7:0] load_val = '0, step = '0;

    logic [7:0] cnt0, cnt1, cnt2, cnt3;
    logic       amax0, amin0, ovf0, unf0, err0;
    logic       amax1, amin1, ovf1, unf1, err1;
    logic       amax2, amin2, ovf2, unf2, err2;
    logic       amax3, amin3, ovf3, unf3, err3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // d0: defaults (0..255 wrap), d1: 10..20 saturate, d2: 10..20 wrap, d3: 0..200 wrap
    updown_counter_lim #(.WIDTH(8)) d0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .step(step), .cnt(cnt0), .at_max(amax0), .at_min(amin0),
        .ovf(ovf0), .unf(unf0), .err(err0));
    updown_counter_lim #(.WIDTH(8), .MIN_VAL(8'd10), .MAX_VAL(8'd20), .SAT(1'b1)) d1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .step(step), .cnt(cnt1), .at_max(amax1), .at_min(amin1),
        .ovf(ovf1), .unf(unf1), .err(err1));
    updown_counter_lim #(.WIDTH(8), .MIN_VAL(8'd10), .MAX_VAL(8'd20), .SAT(1'b0)) d2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .step(step), .cnt(cnt2), .at_max(amax2), .at_min(amin2),
        .ovf(ovf2), .unf(unf2), .err(err2));
    updown_counter_lim #(.WIDTH(8), .MIN_VAL(8'd0), .MAX_VAL(8'd200), .SAT(1'b0)) d3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .step(step), .cnt(cnt3), .at_max(amax3), .at_min(amin3),
        .ovf(ovf3), .unf(unf3), .err(err3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one request, clock it in, and sample 1 time unit after the edge.
    task automatic cyc(input logic c, input logic l, input logic [7:0] lv,
                       input logic i, input logic d, input logic [7:0] s);
        clr = c; load = l; load_val = lv; inc = i; dec = d; step = s;
        @(posedge clk);
        #1;
        $display("t=%0t clr=%0b load=%0b lv=%0d inc=%0b dec=%0b step=%0d | d0=%0d d1=%0d d2=%0d d3=%0d",
                 $time, c, l, lv, i, d, s, cnt0, cnt1, cnt2, cnt3);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        check("rst_cnt0", cnt0, 0);
        check("rst_flags0", {ovf0, unf0, err0}, 0);
        check("rst_cnt1", cnt1, 10);
        check("rst_amin1", amin1, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Load 254: in range for d0, clamped for the narrower instances
        cyc(0, 1, 8'd254, 0, 0, 8'd0);
        check("load254_cnt0", cnt0, 254);
        check("load254_err0", err0, 0);
        check("load254_cnt1", cnt1, 20);
        check("load254_err1", err1, 1);
        check("load254_cnt3", cnt3, 200);
        check("load254_err3", err3, 1);

        // Count up through MAX_VAL and wrap
        cyc(0, 0, 8'd0, 1, 0, 8'd1);
        check("inc255_cnt0", cnt0, 255);
        check("inc255_amax0", amax0, 1);
        check("inc255_ovf0", ovf0, 0);
        cyc(0, 0, 8'd0, 1, 0, 8'd1);
        check("wrap_cnt0", cnt0, 0);
        check("wrap_ovf0", ovf0, 1);
        check("wrap_amin0", amin0, 1);
        cyc(0, 0, 8'd0, 0, 0, 8'd1);
        check("ovf_pulse_end0", ovf0, 0);
        check("idle_hold0", cnt0, 0);

        // Down-wrap from 0, then conflicting inc/dec holds
        cyc(0, 0, 8'd0, 0, 1, 8'd3);
        check("dwrap_cnt0", cnt0, 253);
        check("dwrap_unf0", unf0, 1);
        cyc(0, 0, 8'd0, 1, 1, 8'd5);
        check("both_cnt0", cnt0, 253);
        check("both_flags0", {ovf0, unf0, err0}, 0);

        // 10..20 instances: saturate vs wrap vs oversized step
        cyc(0, 1, 8'd18, 0, 0, 8'd0);
        check("load18_cnt1", cnt1, 18);
        check("load18_cnt2", cnt2, 18);
        cyc(0, 0, 8'd0, 1, 0, 8'd5);
        check("sat_up_cnt1", cnt1, 20);
        check("sat_up_ovf1", ovf1, 1);
        check("wrap_up_cnt2", cnt2, 12);
        check("wrap_up_ovf2", ovf2, 1);
        cyc(0, 0, 8'd0, 0, 1, 8'd15);
        check("sat_dn_cnt1", cnt1, 10);
        check("sat_dn_unf1", unf1, 1);
        check("sat_dn_ovf1", ovf1, 0);
        check("bigstep_dn_cnt2", cnt2, 12);
        check("bigstep_dn_flags2", {ovf2, unf2, err2}, 3'b001);
        cyc(0, 0, 8'd0, 1, 0, 8'd11);
        check("bigstep_up_cnt2", cnt2, 12);
        check("bigstep_up_flags2", {ovf2, unf2, err2}, 3'b001);
        check("sat_big_cnt1", cnt1, 20);
        check("sat_big_ovf1", ovf1, 1);
        cyc(0, 0, 8'd0, 1, 0, 8'd0);
        check("step0_cnt1", cnt1, 20);
        check("step0_flags1", {ovf1, unf1, err1}, 0);
        check("step0_cnt0", cnt0, 19);

        // Priority: clr beats load beats inc
        cyc(1, 1, 8'd5, 1, 0, 8'd1);
        check("clr_cnt0", cnt0, 0);
        check("clr_cnt1", cnt1, 10);
        check("clr_flags1", {ovf1, unf1, err1}, 0);
        cyc(0, 1, 8'd150, 1, 0, 8'd1);
        check("load150_cnt3", cnt3, 150);
        check("load150_err3", err3, 0);
        cyc(0, 1, 8'd3, 0, 0, 8'd0);
        check("loadlow_cnt1", cnt1, 10);
        check("loadlow_err1", err1, 1);
        check("loadlow_cnt0", cnt0, 3);

        // Asynchronous reset in the middle of an inc stream
        cyc(0, 1, 8'd100, 0, 0, 8'd0);
        check("load100_cnt0", cnt0, 100);
        cyc(0, 0, 8'd0, 1, 0, 8'd1);
        check("stream_cnt0", cnt0, 101);
        check("stream_ovf1", ovf1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_cnt0", cnt0, 0);
        check("async_cnt1", cnt1, 10);
        check("async_ovf1", ovf1, 0);
        @(posedge clk);
        #1;
        check("held_cnt0", cnt0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 8'd0, 1, 0, 8'd1);
        check("resume_cnt0", cnt0, 1);
        check("resume_cnt1", cnt1, 11);
        cyc(0, 0, 8'd0, 1, 0, 8'd1);
        check("resume2_cnt0", cnt0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
